rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that turns up to eight simultaneous request lines into a single registered one-hot grant. It sits directly upstream of the 8-to-3 encoder: its `grant` bus is the encoder's data input, so the encoder only ever sees zero or exactly one bit set. Fairness is rotating priority. An optional watchdog forces release of a grant that is never returned.

---
 rtl/rr_arbiter8.sv | 141 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant and rotating priority.
// Define ARB_TIMEOUT_EN to build in the watchdog that revokes a grant after TIMEOUT cycles.
module rr_arbiter8 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout,
    output logic       dbg_state,
    output logic [2:0] dbg_ptr
);

    // Handshake: req is a level held by the requester. grant is one-hot or zero.
    // The grantee owns the resource while its grant bit is high and returns it
    // by pulsing done; done outside GRANT and req changes during GRANT are ignored.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] grant_q, grant_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic        any_req;
    logic        expire;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT must be within 1..255");
    end

    // Rotate so that bit 0 of req_rot is the channel at ptr, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr_q +: 8];
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) win_off = 3'(k);
        end
        win_idx = ptr_q + win_off;
        any_req = |req;
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // A simultaneous done wins over expiry, so no timeout pulse is raised then.
    assign expire = (state_q == GRANT) && !done && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (any_req) cnt_d = 8'd0;
        end else if (!done) begin
            if (expire) timeout_d = 1'b1;
            else        cnt_d     = cnt_q + 8'd1;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            grant_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic; the grant vector is loaded only on the IDLE->GRANT edge.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = win_idx;
                    grant_d = 8'b1 << win_idx;
                end
            end
            GRANT: begin
                if (done || expire) begin
                    state_d = IDLE;
                    grant_d = 8'h00;
                    ptr_d   = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'h00;
            end
        endcase
    end

    // Outputs
    always_comb begin
        grant     = grant_q;
        busy      = (state_q == GRANT);
        dbg_state = state_q;
        dbg_ptr   = ptr_q;
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, priority skip, hold, watchdog, reset mid-grant.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;
    logic       dbg_state;
    logic [2:0] dbg_ptr;

    int errors = 0;
    int checks = 0;

    rr_arbiter8 #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        tick();
        tick();
        checks++;
        if (grant !== 8'h00) begin
            $display("FAIL reset_grant: got %h want 00", grant); errors++;
        end
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b0 || dbg_state !== 1'b0) begin
            $display("FAIL reset_flags: busy=%b timeout=%b state=%b want 0 0 0", busy, timeout, dbg_state);
            errors++;
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h01 || busy !== 1'b1) begin
            $display("FAIL reset_first_grant: got %h busy=%b want 01 busy=1", grant, busy); errors++;
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        for (int i = 1; i <= 8; i++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== 8'h00 || busy !== 1'b0) begin
                $display("FAIL rotation_gap%0d: got %h busy=%b want 00 busy=0", i, grant, busy); errors++;
            end
            tick();
            exp_g = 8'h01 << (i % 8);
            checks++;
            if (grant !== exp_g) begin
                $display("FAIL rotation_grant%0d: got %h want %h", i, grant, exp_g); errors++;
            end
        end
    endtask

    task automatic test_priority_skip();
        req  = 8'h20;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h20) begin
            $display("FAIL skip_ch5: got %h want 20", grant); errors++;
        end
        req  = 8'b0010_0101;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (dbg_ptr !== 3'd6) begin
            $display("FAIL skip_ptr: got %0d want 6", dbg_ptr); errors++;
        end
        tick();
        checks++;
        if (grant !== 8'h01) begin
            $display("FAIL skip_wrap: got %h want 01", grant); errors++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h04) begin
            $display("FAIL skip_next: got %h want 04", grant); errors++;
        end
    endtask

    task automatic test_hold_ignore();
        int hold_cycles;
`ifdef ARB_TIMEOUT_EN
        hold_cycles = 3;
`else
        hold_cycles = 10;
`endif
        req  = 8'h08;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h08) begin
            $display("FAIL hold_grant3: got %h want 08", grant); errors++;
        end
        req = 8'h40;
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            checks++;
            if (grant !== 8'h08) begin
                $display("FAIL hold_cycle%0d: got %h want 08", i, grant); errors++;
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 8'h00) begin
            $display("FAIL hold_release: got %h want 00", grant); errors++;
        end
        tick();
        checks++;
        if (grant !== 8'h40) begin
            $display("FAIL hold_next: got %h want 40", grant); errors++;
        end
    endtask

    task automatic test_watchdog();
        req  = 8'h04;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h04) begin
            $display("FAIL wd_grant2: got %h want 04", grant); errors++;
        end
        req = 8'h0C;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (grant !== 8'h04 || timeout !== 1'b0) begin
                $display("FAIL wd_hold%0d: got %h timeout=%b want 04 timeout=0", i, grant, timeout); errors++;
            end
        end
        tick();
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b1) begin
            $display("FAIL wd_revoke: got %h timeout=%b want 00 timeout=1", grant, timeout); errors++;
        end
        tick();
        checks++;
        if (grant !== 8'h08 || timeout !== 1'b0) begin
            $display("FAIL wd_next: got %h timeout=%b want 08 timeout=0", grant, timeout); errors++;
        end
`else
        for (int i = 1; i <= 50; i++) begin
            tick();
            checks++;
            if (grant !== 8'h04 || timeout !== 1'b0) begin
                $display("FAIL wd_hold%0d: got %h timeout=%b want 04 timeout=0", i, grant, timeout); errors++;
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            $display("FAIL wd_release: got %h timeout=%b want 00 timeout=0", grant, timeout); errors++;
        end
        tick();
        checks++;
        if (grant !== 8'h08) begin
            $display("FAIL wd_next: got %h want 08", grant); errors++;
        end
`endif
    endtask

    task automatic test_reset_mid_grant();
        req  = 8'h10;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (grant !== 8'h10) begin
            $display("FAIL mid_grant4: got %h want 10", grant); errors++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h00;
        checks++;
        if (grant !== 8'h00 || dbg_ptr !== 3'd0 || timeout !== 1'b0 || dbg_state !== 1'b0) begin
            $display("FAIL mid_reset: grant=%h ptr=%0d timeout=%b state=%b want 00 0 0 0",
                     grant, dbg_ptr, timeout, dbg_state);
            errors++;
        end
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 8'h00 || dbg_ptr !== 3'd0 || busy !== 1'b0) begin
            $display("FAIL idle_done_ignored: grant=%h ptr=%0d busy=%b want 00 0 0", grant, dbg_ptr, busy);
            errors++;
        end
        req = 8'h11;
        tick();
        checks++;
        if (grant !== 8'h01) begin
            $display("FAIL mid_first_grant: got %h want 01", grant); errors++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        test_reset();
        test_rotation();
        test_priority_skip();
        test_hold_ignore();
        test_watchdog();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
